// File: rtl/vid_pkg.sv
// vid_pkg: screen geometry, fill byte and control-character codes shared by the text writer.
package vid_pkg;
    localparam int COLS = 160;
    localparam int ROWS = 60;
    localparam logic [7:0] COL_MAX     = 8'(COLS - 1);
    localparam logic [7:0] ROW_MAX     = 8'(ROWS - 1);
    localparam logic [7:0] FILL_CHAR   = 8'h20;
    localparam logic [7:0] CH_CR       = 8'h0D;
    localparam logic [7:0] CH_LF       = 8'h0A;
    localparam logic [7:0] CH_BS       = 8'h08;
    localparam logic [7:0] CH_FF       = 8'h0C;
    localparam logic [7:0] CH_PRINT_LO = 8'h20;
    localparam logic [7:0] CH_PRINT_HI = 8'h7E;

    function automatic logic [7:0] next_row(input logic [7:0] r);
        return r == ROW_MAX ? 8'd0 : r + 8'd1;
    endfunction
endpackage

// File: rtl/text_cursor_writer_if.sv
// text_cursor_writer_if: byte-stream handshake plus the videomem write port.
interface text_cursor_writer_if;
    logic       in_valid, in_ready, vm_stall, vm_we;
    logic [7:0] in_char, vm_row, vm_col, vm_data;
    modport master(input in_valid, in_char, vm_stall, output in_ready, vm_we, vm_row, vm_col, vm_data);
    modport slave(output in_valid, in_char, vm_stall, input in_ready, vm_we, vm_row, vm_col, vm_data);
endinterface

// File: rtl/text_cursor_writer_cell_sweep.sv
// cell_sweep: row/col sweep counter for single-row or full-screen fills, col fastest.
module cell_sweep
    import vid_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       full_i,
    input  logic       en_i,
    input  logic [7:0] row_i,
    output logic [7:0] row_o,
    output logic [7:0] col_o,
    output logic       done_o
);
    logic [7:0] row_q, row_d, col_q, col_d;
    logic       full_q, full_d, col_end;

    assign col_end = col_q == COL_MAX;
    assign done_o  = en_i & col_end & (~full_q | row_q == ROW_MAX);
    assign row_o   = row_q;
    assign col_o   = col_q;

    always_comb begin
        row_d  = start_i ? row_i : (en_i & col_end) ? next_row(row_q) : row_q;
        col_d  = start_i ? 8'd0 : en_i ? (col_end ? 8'd0 : col_q + 8'd1) : col_q;
        full_d = start_i ? full_i : full_q;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            row_q  <= '0;
            col_q  <= '0;
            full_q <= 1'b0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            full_q <= full_d;
        end
endmodule

// File: rtl/text_cursor_writer.sv
// text_cursor_writer: terminal-style byte writer driving the videomem write port with a tracked cursor.
module text_cursor_writer
    import vid_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    text_cursor_writer_if.master        bus,
    output logic [7:0]                  cur_row,
    output logic [7:0]                  cur_col,
    output logic                        busy
);
    typedef enum logic [1:0] {IDLE, WRITE, CLR_LINE, CLR_SCREEN} state_t;
    state_t     state_q, state_d;
    logic [7:0] row_q, row_d, col_q, col_d, wr_row_q, wr_row_d, wr_col_q, wr_col_d, data_q, data_d;
    logic       we_q, we_d, pend_q, pend_d, bs_q, bs_d;
    logic       sw_start, sw_full, sw_en, sw_done, clearing, commit, accept, printable;
    logic [7:0] sw_row_i, sw_row, sw_col, ch;

    assign ch           = bus.in_char;
    assign printable    = ch >= CH_PRINT_LO && ch <= CH_PRINT_HI;
    assign clearing     = state_q == CLR_LINE || state_q == CLR_SCREEN;
    assign commit       = we_q & ~bus.vm_stall;
    assign sw_en        = clearing & commit;
    assign bus.in_ready = state_q == IDLE && !clear && !pend_q;
    assign accept       = bus.in_valid & bus.in_ready;
    assign bus.vm_we    = we_q;
    assign bus.vm_row   = clearing ? sw_row : wr_row_q;
    assign bus.vm_col   = clearing ? sw_col : wr_col_q;
    assign bus.vm_data  = clearing ? FILL_CHAR : data_q;
    assign cur_row      = row_q;
    assign cur_col      = col_q;
    assign busy         = state_q != IDLE;

    cell_sweep u_sweep (
        .clk(clk), .rst(rst), .start_i(sw_start), .full_i(sw_full), .en_i(sw_en),
        .row_i(sw_row_i), .row_o(sw_row), .col_o(sw_col), .done_o(sw_done)
    );

    // Clear states enter with vm_we low for one cycle, then hold it until the last cell commits.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        wr_row_d = wr_row_q;
        wr_col_d = wr_col_q;
        data_d   = data_q;
        we_d     = we_q;
        bs_d     = bs_q;
        pend_d   = pend_q | clear;
        sw_start = 1'b0;
        sw_full  = 1'b0;
        sw_row_i = next_row(row_q);
        case (state_q)
            IDLE:
                if (clear || pend_q || (accept && ch == CH_FF)) begin
                    state_d  = CLR_SCREEN;
                    sw_start = 1'b1;
                    sw_full  = 1'b1;
                    sw_row_i = 8'd0;
                    pend_d   = 1'b1;
                end else if (accept && (printable || (ch == CH_BS && col_q != 8'd0))) begin
                    state_d  = WRITE;
                    we_d     = 1'b1;
                    bs_d     = !printable;
                    wr_row_d = row_q;
                    wr_col_d = printable ? col_q : col_q - 8'd1;
                    col_d    = printable ? col_q : col_q - 8'd1;
                    data_d   = printable ? ch : FILL_CHAR;
                end else if (accept && ch == CH_CR) begin
                    col_d = 8'd0;
                end else if (accept && ch == CH_LF) begin
                    col_d    = 8'd0;
                    row_d    = next_row(row_q);
                    state_d  = CLR_LINE;
                    sw_start = 1'b1;
                end
            WRITE:
                if (commit) begin
                    we_d    = 1'b0;
                    state_d = IDLE;
                    if (!bs_q && col_q == COL_MAX) begin
                        col_d    = 8'd0;
                        row_d    = next_row(row_q);
                        state_d  = CLR_LINE;
                        sw_start = 1'b1;
                    end else if (!bs_q) begin
                        col_d = col_q + 8'd1;
                    end
                end
            CLR_LINE: begin
                we_d    = ~sw_done;
                state_d = sw_done ? IDLE : CLR_LINE;
            end
            CLR_SCREEN: begin
                we_d = ~sw_done;
                if (sw_done) begin
                    state_d = IDLE;
                    row_d   = 8'd0;
                    col_d   = 8'd0;
                    pend_d  = clear;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            wr_row_q <= '0;
            wr_col_q <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            pend_q   <= 1'b0;
            bs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            wr_row_q <= wr_row_d;
            wr_col_q <= wr_col_d;
            data_q   <= data_d;
            we_q     <= we_d;
            pend_q   <= pend_d;
            bs_q     <= bs_d;
        end
endmodule

// File: tb/tb_text_cursor_writer.sv
// tb_text_cursor_writer: random byte streams scored against a cursor/screen reference model.
module tb_text_cursor_writer;
    logic       clk = 1'b0, rst = 1'b1, clear = 1'b0, busy;
    logic [7:0] cur_row, cur_col;
    int         n_cmp = 0, n_bad = 0, n_writes = 0, stall_pct = 0, mr = 0, mc = 0, w0 = 0;
    logic [23:0] exp_q[$];
    logic [23:0] e_w;

    text_cursor_writer_if bus();
    text_cursor_writer dut (
        .clk(clk), .rst(rst), .clear(clear), .bus(bus),
        .cur_row(cur_row), .cur_col(cur_col), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void push(input int r, input int c, input logic [7:0] d);
        exp_q.push_back({8'(r), 8'(c), d});
    endfunction

    function automatic void clear_row(input int r);
        for (int c = 0; c < 160; c++) push(r, c, 8'h20);
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < 60; r++) clear_row(r);
        mr = 0;
        mc = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] ch);
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            push(mr, mc, ch);
            if (mc == 159) begin
                mc = 0;
                mr = (mr + 1) % 60;
                clear_row(mr);
            end else mc++;
        end else if (ch == 8'h0D) mc = 0;
        else if (ch == 8'h0A) begin
            mc = 0;
            mr = (mr + 1) % 60;
            clear_row(mr);
        end else if (ch == 8'h08 && mc > 0) begin
            mc--;
            push(mr, mc, 8'h20);
        end else if (ch == 8'h0C) model_clear();
    endfunction

    function automatic logic [7:0] rand_print();
        return 8'($urandom_range(32, 126));
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic send(input logic [7:0] ch);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_char  = ch;
        while (!bus.in_ready && n < 40000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready stayed 0, required 1");
        end else model_byte(ch);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < 40000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_pending_writes"}, exp_q.size(), 0);
        check({name, "_row"}, cur_row, mr);
        check({name, "_col"}, cur_col, mc);
    endtask

    // Stall changes just after the rising edge so it is settled when the monitor samples.
    initial forever begin
        @(posedge clk);
        #1 bus.vm_stall = (stall_pct != 0) && ($urandom_range(0, 99) < stall_pct);
    end

    always @(negedge clk)
        if (!rst && bus.vm_we && !bus.vm_stall) begin
            n_writes++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got (%0d,%0d)=%02h, required no write",
                         bus.vm_row, bus.vm_col, bus.vm_data);
            end else begin
                e_w = exp_q.pop_front();
                if ({bus.vm_row, bus.vm_col, bus.vm_data} !== e_w) begin
                    n_bad++;
                    $display("FAIL write: got (%0d,%0d)=%02h, required (%0d,%0d)=%02h",
                             bus.vm_row, bus.vm_col, bus.vm_data, e_w[23:16], e_w[15:8], e_w[7:0]);
                end
            end
        end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_char  = 8'h00;
        bus.vm_stall = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_row", cur_row, 0);
        check("rst_col", cur_col, 0);
        check("rst_we", bus.vm_we, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", bus.in_ready, 1);

        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_char  = 8'h48;
        check("hi_ready_H", bus.in_ready, 1);
        model_byte(8'h48);
        @(negedge clk);
        check("hi_ready_gap1", bus.in_ready, 0);
        bus.in_char = 8'h69;
        @(negedge clk);
        check("hi_ready_i", bus.in_ready, 1);
        model_byte(8'h69);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("hi_ready_gap2", bus.in_ready, 0);
        wait_idle("hi");
        check("hi_col2", cur_col, 2);

        stall_pct = 30;
        repeat (5) send(8'h0A);
        check("row5", cur_row, 5);
        repeat (160) send(rand_print());
        wait_idle("line_wrap");
        check("wrap_row6", cur_row, 6);
        check("wrap_ready", bus.in_ready, 1);

        repeat (53) send(8'h0A);
        check("row59", cur_row, 59);
        send(8'h0A);
        wait_idle("lf_wrap");
        check("lf_wrap_row0", cur_row, 0);
        repeat (37) send(rand_print());
        wait_idle("col37");
        w0 = n_writes;
        send(8'h0D);
        repeat (5) @(negedge clk);
        check("cr_no_write", n_writes - w0, 0);
        check("cr_col0", cur_col, 0);

        w0 = n_writes;
        send(8'h08);
        wait_idle("bs_col0");
        check("bs_col0_no_write", n_writes - w0, 0);
        repeat (3) send(rand_print());
        send(8'h08);
        wait_idle("bs_col3");
        check("bs_col2", cur_col, 2);

        repeat (200) begin
            case ($urandom_range(0, 9))
                6: send(8'h0D);
                7: send(8'h0A);
                8: send(8'h08);
                9: send(8'($urandom_range(0, 1) ? $urandom_range(128, 255) : $urandom_range(0, 7)));
                default: send(rand_print());
            endcase
        end
        wait_idle("random");

        stall_pct = 0;
        send(8'h0C);
        wait_idle("ff");

        stall_pct = 25;
        repeat (4) send(rand_print());
        wait_idle("pre_clear");
        @(negedge clk);
        clear = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_char  = 8'h41;
        #1 check("clear_blocks_ready", bus.in_ready, 0);
        w0 = n_writes;
        model_clear();
        @(negedge clk);
        clear = 1'b0;
        bus.in_valid = 1'b0;
        wait_idle("clear");
        check("clear_write_count", n_writes - w0, 9600);

        repeat (3) send(rand_print());
        wait_idle("pre_rst");
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear();
        repeat (3000) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_we", bus.vm_we, 0);
        check("midrst_vm_row", bus.vm_row, 0);
        check("midrst_vm_col", bus.vm_col, 0);
        check("midrst_vm_data", bus.vm_data, 0);
        check("midrst_cur_row", cur_row, 0);
        check("midrst_cur_col", cur_col, 0);
        check("midrst_busy", busy, 0);
        exp_q.delete();
        mr = 0;
        mc = 0;
        @(negedge clk);
        rst = 1'b0;
        #1 check("post_rst_ready", bus.in_ready, 1);
        send(rand_print());
        wait_idle("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
